// File: rtl/mppt_po_controller.sv
// mppt_po_controller: perturb-and-observe MPPT duty-cycle tracker over a valid/ready sample stream.
// Optional adaptive step size is enabled by defining MPPT_ADAPTIVE_STEP_EN.
module mppt_po_controller #(
  parameter logic [7:0] DUTY_INIT = 8'd128,
  parameter logic [7:0] DUTY_MIN = 8'd16,
  parameter logic [7:0] DUTY_MAX = 8'd240,
  parameter logic [7:0] STEP = 8'd4,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] v_sample,
  input  logic [7:0] i_sample,
  input  logic       sample_valid,
  output logic       sample_ready,
  output logic [7:0] duty,
  output logic       duty_update,
  output logic       dir,
  output logic       busy
);
  localparam logic [2:0] IDLE = 3'd0, SETTLE = 3'd1, ACQ = 3'd2, CALC = 3'd3, DECIDE = 3'd4;
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  logic [2:0] state;
  logic [7:0] cnt, v_q, i_q, step, dn, duty_n;
  logic [15:0] p_now, p_prev;
  logic [8:0] up;
  logic first, eq, lt, do_step, dir_n, hi_clamp, lo_clamp, dir_f;
  assign sample_ready = ena && state == ACQ;
  assign busy = state != IDLE;
  assign eq = p_now == p_prev;
  assign lt = p_now < p_prev;
  assign do_step = first || !eq;
  assign dir_n = (!first && lt) ? ~dir : dir;
  assign up = {1'b0, duty} + {1'b0, step};
  assign dn = duty - step;
  // Compare in 9 bits so an underflowing subtraction still counts as below the floor.
  assign hi_clamp = dir_n && up > {1'b0, DUTY_MAX};
  assign lo_clamp = !dir_n && ({1'b0, duty} < {1'b0, step} + {1'b0, DUTY_MIN});
  assign duty_n = hi_clamp ? DUTY_MAX : lo_clamp ? DUTY_MIN : dir_n ? up[7:0] : dn;
  assign dir_f = hi_clamp ? 1'b0 : lo_clamp ? 1'b1 : dir_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      v_q <= '0;
      i_q <= '0;
      p_now <= '0;
      p_prev <= '0;
      duty <= DUTY_INIT;
      dir <= 1'b1;
      first <= 1'b1;
      duty_update <= 1'b0;
    end else begin
      duty_update <= 1'b0;
      if (!ena) begin
        state <= IDLE;
        first <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            state <= SETTLE;
            cnt <= SETTLE_LOAD;
          end
          SETTLE: begin
            if (cnt == 8'd0) state <= ACQ;
            else cnt <= cnt - 8'd1;
          end
          ACQ: begin
            if (sample_valid) begin
              v_q <= v_sample;
              i_q <= i_sample;
              state <= CALC;
            end
          end
          CALC: begin
            p_now <= 16'(v_q) * 16'(i_q);
            state <= DECIDE;
          end
          DECIDE: begin
            p_prev <= p_now;
            first <= 1'b0;
            state <= SETTLE;
            cnt <= SETTLE_LOAD;
            if (do_step) begin
              duty <= duty_n;
              dir <= dir_f;
              duty_update <= duty_n != duty;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef MPPT_ADAPTIVE_STEP_EN
  logic [1:0] run;
  logic [8:0] dbl;
  assign dbl = {step, 1'b0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= STEP;
      run <= '0;
    end else if (!ena) begin
      run <= '0;
    end else if (state == DECIDE) begin
      if (!first && lt) begin
        step <= (step > 8'd1) ? (step >> 1) : 8'd1;
        run <= '0;
      end else if (first || eq || hi_clamp || lo_clamp) begin
        run <= '0;
      end else if (run == 2'd2) begin
        step <= (dbl > {1'b0, STEP}) ? STEP : dbl[7:0];
        run <= '0;
      end else begin
        run <= run + 2'd1;
      end
    end
  end
`else
  assign step = STEP;
`endif
endmodule

// File: doc/mppt_po_controller.md
# mppt_po_controller

Perturb-and-observe maximum-power-point tracking (MPPT) controller for the renewable energy converter. It takes paired voltage/current samples from the measurement front end over a valid/ready handshake and computes input power. It compares that power against the previous sample and steps the converter PWM duty cycle toward the maximum power point. It sits between the sample path (`ui_in`/`uio_in` derived) and the PWM generator that drives `uo_out`.

## Interface
- `DUTY_INIT`, 128: duty loaded at reset.
- `DUTY_MIN`, 16: lower duty clamp (inclusive).
- `DUTY_MAX`, 240: upper duty clamp (inclusive).
- `STEP`, 4: perturbation step; with adaptive step, the initial and maximum step.
- `SETTLE_CYCLES`, 64: wait after each decision before the next acquisition; range 1..255.

Ports:
- `clk`  in  1: single clock; everything is rising-edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `ena`  in  1: tracking enable.
- `v_sample`  in  8: unsigned voltage sample.
- `i_sample`  in  8: unsigned current sample.
- `sample_valid`  in  1: the sample pair is valid.
- `sample_ready`  out  1: the controller accepts a sample this cycle.
- `duty`  out  8: registered PWM duty command.
- `duty_update`  out  1: one-cycle pulse when `duty` changes.
- `dir`  out  1: perturbation direction; 1 = increase.
- `busy`  out  1: FSM not in IDLE.

## Operation
- States: IDLE, SETTLE, ACQ, CALC, DECIDE.
- IDLE: if `ena`=1, go to SETTLE and load the settle counter with `SETTLE_CYCLES`-1.
- SETTLE: decrement the counter each cycle; at 0, go to ACQ.
- ACQ: `sample_ready`=1. A transfer happens on a cycle with `sample_valid` && `sample_ready`. On transfer, latch `v_sample` and `i_sample` and go to CALC.
- CALC: `p_now` = v*i, 16-bit unsigned, full precision, no truncation. Go to DECIDE.
- DECIDE, first decision after reset or after re-enable (`first`=1):
  - store `p_now` as `p_prev`;
  - step `duty` in `dir`;
  - clear `first`.
- DECIDE, otherwise:
  - `p_now` > `p_prev`: keep `dir` and step.
  - `p_now` < `p_prev`: invert `dir`, then step in the new direction.
  - equal: hold `duty` and `dir`, no `duty_update`.
  - In all cases `p_prev` ← `p_now`.
- After DECIDE, go to SETTLE.
- Step arithmetic is 9-bit.
  - If `duty`+step > `DUTY_MAX`: `duty`=`DUTY_MAX` and `dir`←0.
  - If `duty`−step < `DUTY_MIN` (a negative result counts as below): `duty`=`DUTY_MIN` and `dir`←1.
  - If the clamped value equals the current `duty`, no `duty_update`.
- `ena`=0 in any state: next state is IDLE.
  - `duty`, `dir`, `p_prev` hold.
  - `first`←1.
  - A sample presented in that same cycle is not accepted, because `sample_ready` is forced to 0 combinationally by `ena`.
- Reset values:
  - state IDLE, `duty`=`DUTY_INIT`, `dir`=1;
  - `sample_ready`=0, `duty_update`=0, `busy`=0;
  - `p_prev`=0, `first`=1, settle counter 0.
- Reset mid-operation: immediate return to the reset values. A partial transfer is discarded.

## Timing
- `sample_ready` is a Moore output of ACQ, gated by `ena`. It is high from the first ACQ cycle and low the cycle after the transfer.
- Transfer at edge N: CALC during N..N+1, DECIDE during N+1..N+2.
- `duty` and `duty_update` register at edge N+2. `duty_update` is high for exactly one cycle.
- SETTLE lasts `SETTLE_CYCLES` cycles. `sample_ready` rises `SETTLE_CYCLES` cycles after the DECIDE edge.
- Loop period with zero-wait samples is `SETTLE_CYCLES`+3 cycles.
- `sample_valid` may be held high indefinitely. Exactly one sample is consumed per loop.

## Configuration
- `MPPT_ADAPTIVE_STEP_EN` defined:
  - the step is a register, reset to `STEP`;
  - on each direction reversal in DECIDE, step ← max(step>>1, 1);
  - after 3 consecutive same-direction non-equal decisions, step ← min(step<<1, `STEP`) and the run counter clears.
  - The run counter clears on reversal, equal power, clamp, `ena`=0, and reset.
  - The new step applies from the next decision.
- Not defined: the step is the constant `STEP`, and no step or run registers exist.

## Test plan
- Reset with `ena`=1, `SETTLE_CYCLES`=4 -> `duty`=128, `dir`=1, `sample_ready`=0; `sample_ready` rises 5 cycles after `rst_n` deasserts.
- Samples (100,50) then (100,60) -> first decision gives `duty` 132; power 6000>5000 gives `duty` 136, `dir`=1, each with one `duty_update` pulse 2 cycles after the transfer.
- Next sample (100,40) -> 4000<6000 gives `dir`=0, `duty` 132. Then (100,40) again -> `duty` stays 132, no `duty_update`.
- Preload `duty` 238 with `dir`=1 and rising power -> `duty`=240, `dir`=0. Symmetrically, `duty` 18 with `dir`=0 and rising power -> 16, `dir`=1.
- Drop `ena` during ACQ with `sample_valid`=1 -> no transfer, IDLE next cycle, `duty` unchanged. On re-enable, the first decision stores power without a comparison.
- With `MPPT_ADAPTIVE_STEP_EN` and `STEP`=4 -> alternating power sequence gives steps 4, 2, 1, 1; four increasing powers then grow the step back toward 4.
